// File: rtl/hall_call_collector.sv
// Hall call front end: edge-captures up/down hall buttons into pending slots and
// round-robin offers them one at a time on a valid/ready stream, acking the winner.
module hall_call_collector #(
   parameter int NUM_FLOORS = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_FLOORS-1:0]               up_req,
   input  logic [NUM_FLOORS-1:0]               down_req,
   output logic [NUM_FLOORS-1:0]               up_ack,
   output logic [NUM_FLOORS-1:0]               down_ack,
   output logic                                call_valid,
   output logic [$clog2(NUM_FLOORS)-1:0]       call_floor,
   output logic                                call_dir_up_ndown,
   input  logic                                call_ready
);

   // state | meaning
   // IDLE  | no call offered, call_valid=0
   // OFFER | call_floor/call_dir_up_ndown hold a call waiting for call_ready

   localparam int FLOOR_W = $clog2(NUM_FLOORS);
   localparam int SLOTS   = 2 * NUM_FLOORS;
   localparam int SLOT_W  = $clog2(SLOTS);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t              state_q, state_d;
   logic [SLOTS-1:0]    req_cur, req_prev_q, slot_mask, rise;
   logic [SLOTS-1:0]    pending_q, pending_d, ack_q, taken, cand;
   logic [SLOT_W-1:0]   ptr_q, ptr_d, cur_slot, next_after_cur, start, win_slot;
   logic                win_found, handshake, load;
   logic [FLOOR_W-1:0]  floor_q, floor_d;
   logic                dir_q, dir_d;

   assign req_cur = {down_req, up_req};

   // Top floor has no up button, bottom floor no down button.
   always_comb begin
      slot_mask               = '1;
      slot_mask[NUM_FLOORS-1] = 1'b0;
      slot_mask[NUM_FLOORS]   = 1'b0;
   end

   assign rise      = req_cur & ~req_prev_q & slot_mask;
   assign handshake = (state_q == OFFER) && call_ready;

   assign cur_slot       = dir_q ? SLOT_W'(floor_q) : SLOT_W'(floor_q) + SLOT_W'(NUM_FLOORS);
   assign next_after_cur = (cur_slot == SLOT_W'(SLOTS - 1)) ? '0 : cur_slot + 1'b1;
   assign taken          = handshake ? ({{(SLOTS-1){1'b0}}, 1'b1} << cur_slot) : '0;
   assign cand           = pending_q & ~taken;
   assign start          = handshake ? next_after_cur : ptr_q;

   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_slot  = '0;
      for (int i = 0; i < SLOTS; i++) begin
         idx = (int'(start) + i) % SLOTS;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_slot  = SLOT_W'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = OFFER;
               load    = 1'b1;
            end
         end
         OFFER: begin
            if (handshake) begin
               if (win_found) load = 1'b1;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         if (win_slot < SLOT_W'(NUM_FLOORS)) begin
            floor_d = FLOOR_W'(win_slot);
            dir_d   = 1'b1;
         end else begin
            floor_d = FLOOR_W'(win_slot - SLOT_W'(NUM_FLOORS));
            dir_d   = 1'b0;
         end
      end
   end

   // A rise arriving with the handshake of the same slot wins over the clear.
   assign pending_d = (pending_q & ~taken) | rise;
   assign ptr_d     = handshake ? next_after_cur : ptr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_prev_q <= '0;
         pending_q  <= '0;
         ack_q      <= '0;
         ptr_q      <= '0;
         floor_q    <= '0;
         dir_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= req_cur;
         pending_q  <= pending_d;
         ack_q      <= taken;
         ptr_q      <= ptr_d;
         floor_q    <= floor_d;
         dir_q      <= dir_d;
      end
   end

   assign call_valid        = (state_q == OFFER);
   assign call_floor        = floor_q;
   assign call_dir_up_ndown = dir_q;
   assign up_ack            = ack_q[NUM_FLOORS-1:0];
   assign down_ack          = ack_q[SLOTS-1:NUM_FLOORS];

endmodule

// File: tb/tb_hall_call_collector.sv
// Bench for hall_call_collector: per-cycle vector table plus hand sequences for
// fairness, re-press during handshake and reset during an offer.
module tb_hall_call_collector;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] up_req, down_req, up_ack, down_ack;
   logic       call_valid, call_dir_up_ndown, call_ready;
   logic [2:0] call_floor;

   int checks = 0;
   int errors = 0;

   hall_call_collector #(.NUM_FLOORS(8)) dut (
      .clk(clk), .reset(reset), .up_req(up_req), .down_req(down_req),
      .up_ack(up_ack), .down_ack(down_ack), .call_valid(call_valid),
      .call_floor(call_floor), .call_dir_up_ndown(call_dir_up_ndown),
      .call_ready(call_ready));

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] up;
      logic [7:0] dn;
      logic       rdy;
      logic       ev;
      int         ef;
      logic       ed;
      logic [7:0] eua;
      logic [7:0] eda;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [7:0] up, input logic [7:0] dn,
                      input logic rdy, input logic ev, input int ef, input logic ed,
                      input logic [7:0] eua, input logic [7:0] eda);
      vec_t v;
      v.rst = rst; v.up = up; v.dn = dn; v.rdy = rdy;
      v.ev = ev; v.ef = ef; v.ed = ed; v.eua = eua; v.eda = eda;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; up_req = '0; down_req = '0; call_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_ack;
      int          fair_slot [14];
      reset = 1'b1; up_req = '0; down_req = '0; call_ready = 1'b0;

      // Reset 3 cycles, then a single up press on floor 2
      for (int i = 0; i < 3; i++) add(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h04, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h00, 8'h00, 1, 1, 2, 1, 8'h00, 8'h00);
      add(0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h04, 8'h00);
      add(0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
      // Stalled offer held 10 cycles, then two back-to-back accepts
      add(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h02, 8'h20, 0, 0, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 10; i++) add(0, 8'h02, 8'h20, 0, 1, 1, 1, 8'h00, 8'h00);
      add(0, 8'h02, 8'h20, 1, 1, 5, 0, 8'h02, 8'h00);
      add(0, 8'h02, 8'h20, 1, 0, 0, 0, 8'h00, 8'h20);
      add(0, 8'h02, 8'h20, 1, 0, 0, 0, 8'h00, 8'h00);
      // Masked ends never pend; down on top floor does
      add(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h80, 8'h01, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h80, 8'h01, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h80, 8'h81, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h80, 8'h81, 1, 1, 7, 0, 8'h00, 8'h00);
      add(0, 8'h80, 8'h81, 1, 0, 0, 0, 8'h00, 8'h80);
      add(0, 8'h80, 8'h81, 1, 0, 0, 0, 8'h00, 8'h00);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; up_req = vecs[i].up; down_req = vecs[i].dn;
         call_ready = vecs[i].rdy;
         tick();
         chk("valid", i, call_valid, vecs[i].ev);
         chk("up_ack", i, up_ack, vecs[i].eua);
         chk("down_ack", i, down_ack, vecs[i].eda);
         if (vecs[i].ev || vecs[i].rst) begin
            chk("floor", i, call_floor, vecs[i].ef);
            chk("dir", i, call_dir_up_ndown, vecs[i].ed);
         end
      end
      reset = 1'b0;

      // Fairness: everything pending, expect up0..up6 then dn1..dn7
      for (int k = 0; k < 7; k++) fair_slot[k] = k;
      for (int k = 7; k < 14; k++) fair_slot[k] = k + 2;
      do_reset();
      up_req = 8'hFF; down_req = 8'hFF; call_ready = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 14; k++) begin
         chk("fair_valid", k, call_valid, 1);
         chk("fair_floor", k, call_floor, fair_slot[k] % 8);
         chk("fair_dir", k, call_dir_up_ndown, (fair_slot[k] < 8) ? 1 : 0);
         tick();
         exp_ack = 16'h0001 << fair_slot[k];
         chk("fair_ack", k, {down_ack, up_ack}, exp_ack);
      end
      for (int k = 0; k < 3; k++) begin
         chk("fair_idle", k, call_valid, 0);
         tick();
         chk("fair_noack", k, {down_ack, up_ack}, 0);
      end

      // Re-press of up3 in its own handshake cycle
      do_reset();
      up_req = 8'h08;
      tick();
      up_req = 8'h00;
      tick();
      chk("repress_offer", 0, call_valid, 1);
      tick();
      up_req = 8'h08; call_ready = 1'b1;
      tick();
      chk("repress_valid", 0, call_valid, 0);
      chk("repress_ack", 0, up_ack, 8'h08);
      tick();
      chk("repress_valid", 1, call_valid, 1);
      chk("repress_floor", 1, call_floor, 3);
      chk("repress_dir", 1, call_dir_up_ndown, 1);
      chk("repress_ack", 1, up_ack, 8'h00);
      tick();
      chk("repress_ack", 2, up_ack, 8'h08);
      chk("repress_valid", 2, call_valid, 0);
      tick();
      tick();
      chk("repress_ack", 3, up_ack, 8'h00);
      chk("repress_valid", 3, call_valid, 0);

      // Reset in the middle of an offer with three held requests
      do_reset();
      up_req = 8'h16;
      tick();
      tick();
      chk("rst_pre_valid", 0, call_valid, 1);
      reset = 1'b1; call_ready = 1'b1;
      tick();
      chk("rst_valid", 0, call_valid, 0);
      chk("rst_floor", 0, call_floor, 0);
      chk("rst_dir", 0, call_dir_up_ndown, 0);
      chk("rst_ack", 0, {down_ack, up_ack}, 0);
      reset = 1'b0; call_ready = 1'b0;
      tick();
      chk("rst_recap_valid", 0, call_valid, 0);
      tick();
      chk("rst_recap_valid", 1, call_valid, 1);
      chk("rst_recap_floor", 1, call_floor, 1);
      chk("rst_recap_dir", 1, call_dir_up_ndown, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
